// File: rtl/match_controller_if.sv
// Game-side signal bundle between the match controller and the rest of the
// fighter: frame timing, keyboard, hit detection inputs and game-state outputs.
interface match_controller_if;
  logic        frame_clk;
  logic [31:0] keycode;
  logic        collision;
  logic        punch;
  logic        kick;
  logic        crouchpunch;
  logic        block;
  logic        punch2;
  logic        kick2;
  logic        crouchpunch2;
  logic        block2;
  logic        ballcollision;
  logic        ballcollision2;
  logic        start;
  logic        startscreen;
  logic [6:0]  health1;
  logic [6:0]  health2;
  logic [6:0]  timer_secs;
  logic [1:0]  wins1;
  logic [1:0]  wins2;
  logic [2:0]  round_num;
  logic [1:0]  winner;
  logic        hit_flash1;
  logic        hit_flash2;

  // Game side: drives frame timing, keys and hit detection, observes state
  modport master (
    output frame_clk, keycode, collision,
    output punch, kick, crouchpunch, block,
    output punch2, kick2, crouchpunch2, block2,
    output ballcollision, ballcollision2,
    input  start, startscreen, health1, health2, timer_secs,
    input  wins1, wins2, round_num, winner, hit_flash1, hit_flash2
  );

  // Controller side
  modport slave (
    input  frame_clk, keycode, collision,
    input  punch, kick, crouchpunch, block,
    input  punch2, kick2, crouchpunch2, block2,
    input  ballcollision, ballcollision2,
    output start, startscreen, health1, health2, timer_secs,
    output wins1, wins2, round_num, winner, hit_flash1, hit_flash2
  );
endinterface

// File: rtl/match_controller.sv
// Match controller for the two-player fighter: sequences title, fight, KO and
// match-over, arbitrates hits into at most one damage event per victim per
// frame, and keeps health, round timer and round wins. Everything advances on
// frame ticks recovered from the VGA vertical sync.
module match_controller #(
  parameter int          MAX_HEALTH    = 100,
  parameter int          PUNCH_DMG     = 5,
  parameter int          CPUNCH_DMG    = 6,
  parameter int          KICK_DMG      = 8,
  parameter int          BALL_DMG      = 10,
  parameter int          BLOCK_SHIFT   = 2,
  parameter int          IFRAMES       = 30,
  parameter int          ROUND_SECS    = 99,
  parameter int          FPS           = 60,
  parameter int          KO_FRAMES     = 120,
  parameter int          ROUNDS_TO_WIN = 2,
  parameter logic [7:0]  START_KEY     = 8'h28
) (
  input logic Clk,
  input logic Reset_n,
  match_controller_if.slave bus
);

  localparam int FW = $clog2(FPS + 1);
  localparam int KW = $clog2(KO_FRAMES + 1);
  localparam int IW = $clog2(IFRAMES + 1);

  localparam logic [6:0]    HEALTH_INIT = 7'(MAX_HEALTH);
  localparam logic [6:0]    TIMER_INIT  = 7'(ROUND_SECS);
  localparam logic [6:0]    DMG_PUNCH   = 7'(PUNCH_DMG);
  localparam logic [6:0]    DMG_CPUNCH  = 7'(CPUNCH_DMG);
  localparam logic [6:0]    DMG_KICK    = 7'(KICK_DMG);
  localparam logic [6:0]    DMG_BALL    = 7'(BALL_DMG);
  localparam logic [FW-1:0] FRAME_LAST  = FW'(FPS - 1);
  localparam logic [KW-1:0] KO_LAST     = KW'(KO_FRAMES - 1);
  localparam logic [IW-1:0] IFRAME_LOAD = IW'(IFRAMES);
  localparam logic [1:0]    WINS_NEEDED = 2'(ROUNDS_TO_WIN);

  typedef enum logic [1:0] {TITLE, FIGHT, KO, MATCH_OVER} state_t;

  state_t        state;
  logic          start_q, startscreen_q;
  logic [6:0]    health1_q, health2_q, timer_q;
  logic [1:0]    wins1_q, wins2_q, winner_q;
  logic [2:0]    round_q;
  logic [FW-1:0] frame_q;
  logic [KW-1:0] ko_q;
  logic [IW-1:0] ifr1_q, ifr2_q;

  logic          fc_meta, fc_sync, fc_prev;
  logic          tick;
  logic          start_det;

  // Attack flags packed as {kick, crouchpunch, punch}: higher bit wins priority
  logic [2:0]    atk1, atk2, atk1_q, atk2_q, rise1, rise2;

  logic [6:0]    dmg1, dmg2, health1_n, health2_n, timer_n;
  logic [FW-1:0] frame_n;
  logic [IW-1:0] ifr1_n, ifr2_n;
  logic          frame_wrap;
  logic          round_over;
  logic [1:0]    round_winner;

  // Damage one victim takes this frame: strongest source wins, nothing while
  // invulnerable, and blocking scales it down (possibly to zero)
  function automatic logic [6:0] hit_damage(input logic ball, input logic coll,
                                            input logic [2:0] rise,
                                            input logic [IW-1:0] ifr,
                                            input logic blk);
    logic [6:0] d;
    if (ball)                  d = DMG_BALL;
    else if (coll && rise[2])  d = DMG_KICK;
    else if (coll && rise[1])  d = DMG_CPUNCH;
    else if (coll && rise[0])  d = DMG_PUNCH;
    else                       d = 7'd0;
    if (ifr != '0) d = 7'd0;
    if (blk)       d = d >> BLOCK_SHIFT;
    return d;
  endfunction

  function automatic logic [6:0] sat_sub(input logic [6:0] h, input logic [6:0] d);
    return (h > d) ? h - d : 7'd0;
  endfunction

  // A real hit restarts invulnerability; otherwise it drains toward zero
  function automatic logic [IW-1:0] ifr_next(input logic [IW-1:0] ifr, input logic [6:0] d);
    if (d != 7'd0)     return IFRAME_LOAD;
    else if (ifr != '0) return ifr - IW'(1);
    else                return '0;
  endfunction

  // Bring VGA vsync into the Clk domain, with one extra stage for edge detect
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fc_meta <= 1'b0;
      fc_sync <= 1'b0;
      fc_prev <= 1'b0;
    end else begin
      fc_meta <= bus.frame_clk;
      fc_sync <= fc_meta;
      fc_prev <= fc_sync;
    end
  end

  assign tick = fc_sync & ~fc_prev;

  // The start key may appear in any of the four keycode slots
  always_comb begin
    start_det = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.keycode[8*i +: 8] == START_KEY) start_det = 1'b1;
    end
  end

  assign atk1  = {bus.kick,  bus.crouchpunch,  bus.punch};
  assign atk2  = {bus.kick2, bus.crouchpunch2, bus.punch2};
  assign rise1 = atk1 & ~atk1_q;
  assign rise2 = atk2 & ~atk2_q;

  // Attack flags sampled frame-to-frame so a held button lands only once
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      atk1_q <= 3'b000;
      atk2_q <= 3'b000;
    end else if (tick) begin
      atk1_q <= atk1;
      atk2_q <= atk2;
    end
  end

  // Next fight-frame values: timer, damage trade and round-end decision
  always_comb begin
    frame_wrap = (frame_q == FRAME_LAST);
    frame_n    = frame_wrap ? '0 : frame_q + FW'(1);
    timer_n    = (frame_wrap && timer_q != 7'd0) ? timer_q - 7'd1 : timer_q;

    dmg1      = hit_damage(bus.ballcollision2, bus.collision, rise2, ifr1_q, bus.block);
    dmg2      = hit_damage(bus.ballcollision,  bus.collision, rise1, ifr2_q, bus.block2);
    health1_n = sat_sub(health1_q, dmg1);
    health2_n = sat_sub(health2_q, dmg2);
    ifr1_n    = ifr_next(ifr1_q, dmg1);
    ifr2_n    = ifr_next(ifr2_q, dmg2);

    round_over   = 1'b1;
    round_winner = 2'b00;
    if (health1_n == 7'd0 && health2_n == 7'd0) begin
      round_winner = 2'b11;
    end else if (health1_n == 7'd0) begin
      round_winner = 2'b10;
    end else if (health2_n == 7'd0) begin
      round_winner = 2'b01;
    end else if (timer_n == 7'd0) begin
      if (health1_n > health2_n)      round_winner = 2'b01;
      else if (health2_n > health1_n) round_winner = 2'b10;
      else                            round_winner = 2'b11;
    end else begin
      round_over = 1'b0;
    end
  end

  // Game-flow state machine; all game state moves only on a frame tick
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= TITLE;
      start_q       <= 1'b0;
      startscreen_q <= 1'b1;
      health1_q     <= HEALTH_INIT;
      health2_q     <= HEALTH_INIT;
      timer_q       <= TIMER_INIT;
      wins1_q       <= 2'd0;
      wins2_q       <= 2'd0;
      round_q       <= 3'd1;
      winner_q      <= 2'b00;
      frame_q       <= '0;
      ko_q          <= '0;
      ifr1_q        <= '0;
      ifr2_q        <= '0;
    end else if (tick) begin
      unique case (state)
        TITLE: begin
          if (start_det) begin
            state         <= FIGHT;
            start_q       <= 1'b1;
            startscreen_q <= 1'b0;
            health1_q     <= HEALTH_INIT;
            health2_q     <= HEALTH_INIT;
            timer_q       <= TIMER_INIT;
            frame_q       <= '0;
            ifr1_q        <= '0;
            ifr2_q        <= '0;
            winner_q      <= 2'b00;
          end
        end
        FIGHT: begin
          frame_q   <= frame_n;
          timer_q   <= timer_n;
          health1_q <= health1_n;
          health2_q <= health2_n;
          ifr1_q    <= ifr1_n;
          ifr2_q    <= ifr2_n;
          if (round_over) begin
            winner_q <= round_winner;
            if (round_winner == 2'b01 && wins1_q != 2'd3) wins1_q <= wins1_q + 2'd1;
            if (round_winner == 2'b10 && wins2_q != 2'd3) wins2_q <= wins2_q + 2'd1;
            state   <= KO;
            start_q <= 1'b0;
            ko_q    <= '0;
          end
        end
        KO: begin
          if (ko_q == KO_LAST) begin
            if (wins1_q == WINS_NEEDED || wins2_q == WINS_NEEDED) begin
              state <= MATCH_OVER;
            end else begin
              state     <= FIGHT;
              start_q   <= 1'b1;
              round_q   <= (round_q == 3'd7) ? 3'd7 : round_q + 3'd1;
              health1_q <= HEALTH_INIT;
              health2_q <= HEALTH_INIT;
              timer_q   <= TIMER_INIT;
              frame_q   <= '0;
              ifr1_q    <= '0;
              ifr2_q    <= '0;
              winner_q  <= 2'b00;
            end
          end else begin
            ko_q <= ko_q + KW'(1);
          end
        end
        MATCH_OVER: begin
          if (start_det) begin
            state         <= TITLE;
            start_q       <= 1'b0;
            startscreen_q <= 1'b1;
            health1_q     <= HEALTH_INIT;
            health2_q     <= HEALTH_INIT;
            timer_q       <= TIMER_INIT;
            wins1_q       <= 2'd0;
            wins2_q       <= 2'd0;
            round_q       <= 3'd1;
            winner_q      <= 2'b00;
            frame_q       <= '0;
            ko_q          <= '0;
            ifr1_q        <= '0;
            ifr2_q        <= '0;
          end
        end
        default: state <= TITLE;
      endcase
    end
  end

  assign bus.start       = start_q;
  assign bus.startscreen = startscreen_q;
  assign bus.health1     = health1_q;
  assign bus.health2     = health2_q;
  assign bus.timer_secs  = timer_q;
  assign bus.wins1       = wins1_q;
  assign bus.wins2       = wins2_q;
  assign bus.round_num   = round_q;
  assign bus.winner      = winner_q;
  assign bus.hit_flash1  = (ifr1_q != '0);
  assign bus.hit_flash2  = (ifr2_q != '0);

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed match scenarios plus a
// randomized stretch, all checked each frame against a rule-level game model.
`timescale 1ns/1ps
module tb_match_controller;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  event tickDone;

  match_controller_if bus();
  match_controller dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));

  // 100 MHz bench clock
  always #5 clk = ~clk;

  localparam int P_TITLE = 0, P_FIGHT = 1, P_KO = 2, P_OVER = 3;

  int mPhase, mTimer, mFrame, mRound, mWinner, mKo;
  int mHealth[2], mIfr[2], mWins[2];
  bit mPrev[2][3];

  task automatic checkOutput(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic modelNewRound();
    for (int p = 0; p < 2; p++) begin
      mHealth[p] = 100;
      mIfr[p]    = 0;
    end
    mTimer  = 99;
    mFrame  = 0;
    mWinner = 0;
  endtask

  task automatic modelMatchReload();
    modelNewRound();
    mPhase  = P_TITLE;
    mWins[0] = 0;
    mWins[1] = 0;
    mRound  = 1;
    mKo     = 0;
  endtask

  task automatic modelReset();
    modelMatchReload();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 3; k++) mPrev[p][k] = 0;
  endtask

  // One frame of game rules, read straight from the current inputs
  task automatic modelTick();
    bit startKey;
    bit atk[2][3];
    bit rise[2][3];
    bit ball[2];
    bit blk[2];
    int dmg, w;
    bit over;
    int dmgTable[3] = '{5, 6, 8};
    logic [31:0] kc;
    kc = bus.keycode;
    startKey = 0;
    for (int i = 0; i < 4; i++)
      if (((kc >> (8 * i)) & 32'hFF) == 32'h28) startKey = 1;
    atk[0] = '{bus.punch,  bus.crouchpunch,  bus.kick};
    atk[1] = '{bus.punch2, bus.crouchpunch2, bus.kick2};
    ball[0] = bus.ballcollision;
    ball[1] = bus.ballcollision2;
    blk[0]  = bus.block;
    blk[1]  = bus.block2;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 3; k++) begin
        rise[p][k] = atk[p][k] && !mPrev[p][k];
        mPrev[p][k] = atk[p][k];
      end
    case (mPhase)
      P_TITLE: if (startKey) begin
        mPhase = P_FIGHT;
        modelNewRound();
      end
      P_FIGHT: begin
        mFrame++;
        if (mFrame == 60) begin
          mFrame = 0;
          if (mTimer > 0) mTimer--;
        end
        for (int v = 0; v < 2; v++) begin
          int a;
          a = 1 - v;
          dmg = 0;
          if (ball[a]) dmg = 10;
          else if (bus.collision)
            for (int k = 2; k >= 0; k--)
              if (rise[a][k] && dmg == 0) dmg = dmgTable[k];
          if (mIfr[v] != 0) dmg = 0;
          if (blk[v]) dmg = dmg / 4;
          mHealth[v] = (mHealth[v] > dmg) ? mHealth[v] - dmg : 0;
          if (dmg > 0) mIfr[v] = 30;
          else if (mIfr[v] > 0) mIfr[v]--;
        end
        over = 1;
        w = 0;
        if (mHealth[0] == 0 && mHealth[1] == 0) w = 3;
        else if (mHealth[0] == 0) w = 2;
        else if (mHealth[1] == 0) w = 1;
        else if (mTimer == 0) w = (mHealth[0] > mHealth[1]) ? 1 : (mHealth[1] > mHealth[0]) ? 2 : 3;
        else over = 0;
        if (over) begin
          mWinner = w;
          if (w == 1 && mWins[0] < 3) mWins[0]++;
          if (w == 2 && mWins[1] < 3) mWins[1]++;
          mPhase = P_KO;
          mKo = 0;
        end
      end
      P_KO: begin
        mKo++;
        if (mKo == 120) begin
          if (mWins[0] == 2 || mWins[1] == 2) mPhase = P_OVER;
          else begin
            mRound = (mRound < 7) ? mRound + 1 : 7;
            modelNewRound();
            mPhase = P_FIGHT;
          end
        end
      end
      default: if (startKey) modelMatchReload();
    endcase
  endtask

  // Drive one frame's inputs and pulse frame_clk around them
  task automatic applyStimulus(input logic [31:0] kc, input logic col,
                               input logic [2:0] atk1, input logic blk1,
                               input logic [2:0] atk2, input logic blk2,
                               input logic ball1, input logic ball2);
    @(negedge clk);
    bus.keycode   = kc;
    bus.collision = col;
    {bus.kick,  bus.crouchpunch,  bus.punch}  = atk1;
    {bus.kick2, bus.crouchpunch2, bus.punch2} = atk2;
    bus.block          = blk1;
    bus.block2         = blk2;
    bus.ballcollision  = ball1;
    bus.ballcollision2 = ball2;
    bus.frame_clk = 1'b1;
    repeat (3) @(negedge clk);
    modelTick();
    bus.frame_clk = 1'b0;
    repeat (2) @(negedge clk);
    -> tickDone;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'h0, 0, 3'b000, 0, 3'b000, 0, 0, 0);
  endtask

  task automatic p1Kick();
    applyStimulus(32'h0, 1, 3'b100, 0, 3'b000, 0, 0, 0);
  endtask

  // Compare every output against the model after each frame
  initial begin
    forever begin
      @(tickDone);
      checkOutput("start",       bus.start,       (mPhase == P_FIGHT) ? 1 : 0);
      checkOutput("startscreen", bus.startscreen, (mPhase == P_TITLE) ? 1 : 0);
      checkOutput("health1",     bus.health1,     mHealth[0]);
      checkOutput("health2",     bus.health2,     mHealth[1]);
      checkOutput("timer_secs",  bus.timer_secs,  mTimer);
      checkOutput("wins1",       bus.wins1,       mWins[0]);
      checkOutput("wins2",       bus.wins2,       mWins[1]);
      checkOutput("round_num",   bus.round_num,   mRound);
      checkOutput("winner",      bus.winner,      mWinner);
      checkOutput("hit_flash1",  bus.hit_flash1,  (mIfr[0] != 0) ? 1 : 0);
      checkOutput("hit_flash2",  bus.hit_flash2,  (mIfr[1] != 0) ? 1 : 0);
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_startscreen"}, bus.startscreen, 1);
    checkOutput({tag, "_start"},       bus.start,       0);
    checkOutput({tag, "_health1"},     bus.health1,     100);
    checkOutput({tag, "_health2"},     bus.health2,     100);
    checkOutput({tag, "_timer"},       bus.timer_secs,  99);
    checkOutput({tag, "_wins1"},       bus.wins1,       0);
    checkOutput({tag, "_wins2"},       bus.wins2,       0);
    checkOutput({tag, "_round"},       bus.round_num,   1);
    checkOutput({tag, "_winner"},      bus.winner,      0);
    checkOutput({tag, "_flash2"},      bus.hit_flash2,  0);
  endtask

  // Directed match walk-through followed by randomized play
  initial begin
    logic [31:0] kc;
    logic [2:0]  a1, a2;
    rst_n = 1'b0;
    bus.frame_clk = 1'b0;
    bus.keycode = '0;
    bus.collision = 0;
    {bus.punch, bus.kick, bus.crouchpunch, bus.block} = '0;
    {bus.punch2, bus.kick2, bus.crouchpunch2, bus.block2} = '0;
    bus.ballcollision = 0;
    bus.ballcollision2 = 0;
    modelReset();
    #23;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;

    idle(2);
    applyStimulus(32'h00000028, 0, 3'b000, 0, 3'b000, 0, 0, 0);
    checkOutput("enter_start", bus.start, 1);
    checkOutput("enter_startscreen", bus.startscreen, 0);
    checkOutput("enter_timer", bus.timer_secs, 99);

    // Held kick lands once; flash lasts 30 frames
    for (int i = 0; i < 40; i++) begin
      p1Kick();
      if (i == 0)  checkOutput("kick_hit_health2", bus.health2, 92);
      if (i == 29) checkOutput("flash_last_frame", bus.hit_flash2, 1);
      if (i == 30) checkOutput("flash_cleared", bus.hit_flash2, 0);
    end
    checkOutput("kick_held_health2", bus.health2, 92);
    applyStimulus(32'h0, 1, 3'b000, 0, 3'b000, 0, 0, 0);
    p1Kick();
    checkOutput("kick_again_health2", bus.health2, 84);
    idle(30);

    // Ball beats punch, then blocked down to 10>>2
    applyStimulus(32'h0, 1, 3'b001, 0, 3'b000, 1, 1, 0);
    checkOutput("ball_blocked_health2", bus.health2, 82);
    checkOutput("ball_blocked_health1", bus.health1, 100);
    idle(30);

    // Trade on the same frame
    applyStimulus(32'h0, 1, 3'b100, 0, 3'b001, 0, 0, 0);
    checkOutput("trade_health1", bus.health1, 95);
    checkOutput("trade_health2", bus.health2, 74);
    idle(30);

    // Knock P2 out
    for (int n = 0; n < 20 && mPhase == P_FIGHT; n++) begin
      p1Kick();
      if (mPhase == P_FIGHT) idle(30);
    end
    checkOutput("ko_health2", bus.health2, 0);
    checkOutput("ko_winner", bus.winner, 1);
    checkOutput("ko_wins1", bus.wins1, 1);
    for (int i = 0; i < 120; i++) begin
      idle(1);
      if (i == 118) checkOutput("ko_still_paused", bus.start, 0);
    end
    checkOutput("round2_start", bus.start, 1);
    checkOutput("round2_num", bus.round_num, 2);
    checkOutput("round2_health2", bus.health2, 100);

    // Timeout with equal health is a draw
    for (int i = 0; i < 99 * 60; i++) begin
      idle(1);
      if (i == 99 * 60 - 2) checkOutput("timeout_not_yet", bus.start, 1);
    end
    checkOutput("draw_winner", bus.winner, 3);
    checkOutput("draw_timer", bus.timer_secs, 0);
    checkOutput("draw_wins1", bus.wins1, 1);
    checkOutput("draw_wins2", bus.wins2, 0);
    idle(120);
    checkOutput("round3_num", bus.round_num, 3);

    // Second P1 round win takes the match
    for (int n = 0; n < 20 && mPhase == P_FIGHT; n++) begin
      p1Kick();
      if (mPhase == P_FIGHT) idle(30);
    end
    checkOutput("match_wins1", bus.wins1, 2);
    idle(120);
    checkOutput("over_winner", bus.winner, 1);
    checkOutput("over_start", bus.start, 0);
    checkOutput("over_startscreen", bus.startscreen, 0);
    applyStimulus(32'h28000000, 0, 3'b000, 0, 3'b000, 0, 0, 0);
    checkOutput("restart_startscreen", bus.startscreen, 1);
    checkOutput("restart_wins1", bus.wins1, 0);
    checkOutput("restart_round", bus.round_num, 1);

    // Randomized play
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) kc = 32'h28 << (8 * $urandom_range(0, 3));
      else kc = $urandom & 32'h0F0F0F0F;
      for (int k = 0; k < 3; k++) begin
        a1[k] = ($urandom_range(0, 2) == 0);
        a2[k] = ($urandom_range(0, 2) == 0);
      end
      applyStimulus(kc, 1'($urandom_range(0, 1)), a1, ($urandom_range(0, 3) == 0),
                    a2, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0));
    end

    // Get back into a fight, then reset mid-round
    for (int n = 0; n < 300 && mPhase != P_FIGHT; n++)
      applyStimulus(32'h00000028, 0, 3'b000, 0, 3'b000, 0, 0, 0);
    checkOutput("reach_fight_start", bus.start, 1);
    applyStimulus(32'h0, 1, 3'b010, 0, 3'b000, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    applyStimulus(32'h00280000, 0, 3'b000, 0, 3'b000, 0, 0, 0);
    idle(2);

    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Game-flow sequencer and damage arbiter for the two-player fighter.
- Owns title/fight/KO/match-over sequencing and drives `start`/`startscreen` to the movement, cannon and colour-mapper blocks.
- Arbitrates simultaneous hit sources into at most one damage event per victim per frame, and tracks health, round timer and rounds won.
- All game logic advances on frame ticks derived from `frame_clk` (VGA_VS).

Parameters:
- MAX_HEALTH, 100: health at round start (must be ≤127).
- PUNCH_DMG, 5: damage for standing punch.
- CPUNCH_DMG, 6: damage for crouch punch.
- KICK_DMG, 8: damage for kick.
- BALL_DMG, 10: damage for fireball hit.
- BLOCK_SHIFT, 2: blocked damage = dmg >> BLOCK_SHIFT.
- IFRAMES, 30: victim invulnerability frames after a nonzero hit.
- ROUND_SECS, 99: round timer start value.
- FPS, 60: frame ticks per timer second.
- KO_FRAMES, 120: pause length in KO before the next round or match over.
- ROUNDS_TO_WIN, 2: round wins needed to take the match.
- START_KEY, 8'h28: keycode byte that starts or restarts the match.

Ports:
- Clk  in  1  system clock (MAX10_CLK1_50).
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  VGA_VS level, asynchronous to Clk.
- keycode  in  32  four USB keycode bytes.
- collision  in  1  player bodies/hitboxes overlap.
- punch, kick, crouchpunch, block  in  1 each  player-1 action flags.
- punch2, kick2, crouchpunch2, block2  in  1 each  player-2 action flags.
- ballcollision  in  1  player-1 ball overlaps player 2.
- ballcollision2  in  1  player-2 ball overlaps player 1.
- start  out  1  high only in FIGHT.
- startscreen  out  1  high only in TITLE.
- health1, health2  out  7  current health.
- timer_secs  out  7  round seconds remaining.
- wins1, wins2  out  2  rounds won.
- round_num  out  3  current round, 1-based.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.
- hit_flash1, hit_flash2  out  1  victim invulnerability counter nonzero.

Behaviour:
- **Reset.** Reset_n low asynchronously forces:
  - state=TITLE, startscreen=1, start=0;
  - health1=health2=MAX_HEALTH, timer_secs=ROUND_SECS;
  - wins=0, round_num=1, winner=00;
  - flashes=0, all counters and edge registers=0.
  - Reset mid-fight aborts the match with no partial state kept.
- **Frame tick.** frame_clk is passed through a 2-FF synchroniser; tick = 1-cycle pulse on the synchronised rising edge. All state and counter updates occur on the tick cycle; outputs are registered and valid the cycle after the tick.
- **Start detect.** Asserted when any of the 4 keycode bytes == START_KEY, sampled at tick.
- **TITLE.** On tick with start detect → FIGHT; load round-start values.
- **FIGHT.** Every tick:
  - Frame counter increments; at FPS-1 it wraps to 0 and timer_secs decrements, saturating at 0.
  - Per victim, candidate sources this tick (P2 shown; P1 symmetric with ballcollision2 and P2 attack flags):
    - ballcollision → BALL_DMG;
    - collision & rising edge of kick → KICK_DMG;
    - collision & rising edge of crouchpunch → CPUNCH_DMG;
    - collision & rising edge of punch → PUNCH_DMG.
  - Attack rising edges are taken tick-to-tick, so one press yields at most one hit.
  - Priority ball > kick > crouchpunch > punch; exactly one source applies per victim per tick.
  - Damage is ignored if the victim's iframe counter ≠ 0.
  - If the victim's block=1, damage >>= BLOCK_SHIFT; 0 is allowed and does not start iframes.
  - Health subtraction saturates at 0. Nonzero damage loads the victim iframe counter with IFRAMES; otherwise the counter decrements to 0.
  - Both players can be damaged on the same tick (trade).
  - Round end is evaluated after damage on the same tick:
    - both health 0 → draw;
    - one health 0 → other wins;
    - else timer reached 0 → higher health wins, equal → draw.
  - On round end: winner set; winner's wins incremented, saturating at 3; → KO with KO counter=0.
- **KO.** start=0, healths frozen. After KO_FRAMES ticks:
  - If either wins == ROUNDS_TO_WIN → MATCH_OVER.
  - Else round_num+1 (saturating at 7), healths/timer/frame counter/iframes reloaded, winner=00 → FIGHT.
  - A draw awards no win, so a match can exceed 3 rounds.
- **MATCH_OVER.** winner holds the match winner; start=0, startscreen=0. Start detect on tick → TITLE with a full reload (same values as reset).

Test Plan:
- Reset, then keycode=32'h00000028, 1 tick → startscreen 1→0, start=1, health1=health2=100, timer_secs=99.
- FIGHT, collision=1, kick rising on one tick and held 40 ticks → health2=92 only once; hit_flash2 high 30 ticks; a second kick press after flash clears → 84.
- Same tick: ballcollision=1, collision=1, punch edge, block2=1 → health2 = 100-(10>>2) = 98 (ball wins priority, blocked).
- Simultaneous P1 kick and P2 punch with collision → health1=95, health2=92 on the same tick.
- Set health2 to 3 via hits, then a kick → health2=0 (saturated), winner=01, wins1=1, KO for 120 ticks, then round_num=2 with healths 100.
- Run 99×60 ticks with equal health → winner=11, no wins change. Two P1 round wins → MATCH_OVER, winner=01. Reset_n low mid-FIGHT → TITLE immediately, all values reset.
